gemm_inst_sequencer: RTL and testbench

- Sequences decoded instructions (opcode, buf_id, mem_loc) from the instruction fetch stage into the systolic-array controller and its SRAM banks.
- LD moves NUM_ROW rows from external memory into the top or left SRAM bank.
- ST moves NUM_ROW rows from the down SRAM bank to external memory.
- GEMM and DRAINSYS drive i_ctrl_state with address windows and hold until the controller reports done.
- Sits between the instruction reader and the controller; owns per-bank address pointers.

---
 rtl/gemm_inst_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_gemm_inst_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_inst_sequencer.sv
// gemm_inst_sequencer: turns decoded LD/ST/GEMM/DRAINSYS instructions into
// SRAM bank traffic and controller commands. Owns the per-bank pointers.
module gemm_inst_sequencer #(
   parameter int OPCODE_WIDTH         = 4,
   parameter int BUF_ID_WIDTH         = 2,
   parameter int MEM_LOC_WIDTH        = 10,
   parameter int NUM_ROW              = 8,
   parameter int NUM_COL              = 8,
   parameter int DATA_WIDTH           = 8,
   parameter int ACCU_DATA_WIDTH      = 32,
   parameter int CTRL_WIDTH           = 4,
   parameter int LOG2_SRAM_BANK_DEPTH = 10,
   parameter logic [OPCODE_WIDTH-1:0] opcode_LD       = 4'b0010,
   parameter logic [OPCODE_WIDTH-1:0] opcode_ST       = 4'b0011,
   parameter logic [OPCODE_WIDTH-1:0] opcode_GEMM     = 4'b0100,
   parameter logic [OPCODE_WIDTH-1:0] opcode_DRAINSYS = 4'b0101,
   parameter logic [CTRL_WIDTH-1:0]   CTRL_IDLE       = 0,
   parameter logic [CTRL_WIDTH-1:0]   CTRL_GEMM       = 1,
   parameter logic [CTRL_WIDTH-1:0]   CTRL_DRAIN      = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 inst_valid,
   output logic                                 inst_ready,
   input  logic [OPCODE_WIDTH-1:0]              opcode,
   input  logic [BUF_ID_WIDTH-1:0]              buf_id,
   input  logic [MEM_LOC_WIDTH-1:0]             mem_loc,
   output logic                                 ext_rd_en,
   output logic [MEM_LOC_WIDTH-1:0]             ext_rd_addr,
   input  logic [NUM_COL*DATA_WIDTH-1:0]        ext_rd_data,
   output logic                                 ext_wr_en,
   output logic [MEM_LOC_WIDTH-1:0]             ext_wr_addr,
   output logic [NUM_COL*ACCU_DATA_WIDTH-1:0]   ext_wr_data,
   output logic                                 i_top_wr_en,
   output logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_top_wr_addr,
   output logic [NUM_COL*DATA_WIDTH-1:0]        i_top_wr_data,
   output logic                                 i_left_wr_en,
   output logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_left_wr_addr,
   output logic [NUM_ROW*DATA_WIDTH-1:0]        i_left_wr_data,
   output logic                                 i_down_rd_en,
   output logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_down_rd_addr,
   input  logic [NUM_COL*ACCU_DATA_WIDTH-1:0]   down_rd_data,
   output logic [CTRL_WIDTH-1:0]                i_ctrl_state,
   output logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_top_sram_rd_start_addr,
   output logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_top_sram_rd_end_addr,
   output logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_left_sram_rd_start_addr,
   output logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_left_sram_rd_end_addr,
   output logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_down_sram_rd_start_addr,
   output logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_down_sram_rd_end_addr,
   input  logic                                 ctrl_done,
   output logic                                 busy,
   output logic                                 err_illegal
);

   localparam int LW    = LOG2_SRAM_BANK_DEPTH;
   localparam int MW    = MEM_LOC_WIDTH;
   localparam int LEFTW = NUM_ROW*DATA_WIDTH;
   localparam int CNT_W = $clog2(NUM_ROW+1);
   localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(NUM_ROW);
   localparam logic [LW-1:0]           ROW_STEP = LW'(NUM_ROW);
   localparam logic [BUF_ID_WIDTH-1:0] BUF_TOP  = BUF_ID_WIDTH'(0);
   localparam logic [BUF_ID_WIDTH-1:0] BUF_LEFT = BUF_ID_WIDTH'(1);
   localparam logic [BUF_ID_WIDTH-1:0] BUF_DOWN = BUF_ID_WIDTH'(2);

   typedef enum logic [2:0] {
      S_IDLE, S_LD_RUN, S_ST_RUN, S_GEMM_WAIT, S_DRAIN_WAIT
   } state_t;

   state_t r_state, w_state_nxt;

   logic [CNT_W-1:0] r_cnt;        // 0..NUM_ROW-1 read phase, 1..NUM_ROW write phase
   logic             r_ld_left;    // LD target: 1=left bank, 0=top bank
   logic [MW-1:0]    r_mem_loc;    // external base (LD/ST) or K (GEMM)
   logic [LW-1:0]    r_top_wr, r_left_wr, r_top_rd, r_left_rd, r_down_drain, r_down_st;
   logic             r_err;
   logic [LW-1:0]    r_top_s, r_top_e, r_left_s, r_left_e, r_down_s, r_down_e;

   logic             w_accept, w_ld_ok, w_st_ok, w_gemm_ok, w_drain_ok, w_nop, w_legal;
   logic             w_last, w_rd_phase, w_wr_phase;
   logic [CNT_W-1:0] w_wr_idx;

   assign w_accept   = inst_valid && (r_state == S_IDLE);
   assign w_ld_ok    = (opcode == opcode_LD) && ((buf_id == BUF_TOP) || (buf_id == BUF_LEFT));
   assign w_st_ok    = (opcode == opcode_ST) && (buf_id == BUF_DOWN);
   assign w_gemm_ok  = (opcode == opcode_GEMM) && (mem_loc != '0);
   assign w_drain_ok = (opcode == opcode_DRAINSYS);
   assign w_nop      = (opcode == '0);
   assign w_legal    = w_ld_ok || w_st_ok || w_gemm_ok || w_drain_ok;
   assign w_last     = (r_cnt == CNT_LAST);
   assign w_rd_phase = (r_cnt < CNT_LAST);
   assign w_wr_phase = (r_cnt != '0);
   assign w_wr_idx   = r_cnt - CNT_W'(1);

   assign inst_ready = (r_state == S_IDLE);
   assign busy       = (r_state != S_IDLE);
   assign err_illegal = r_err;

   assign i_top_sram_rd_start_addr  = r_top_s;
   assign i_top_sram_rd_end_addr    = r_top_e;
   assign i_left_sram_rd_start_addr = r_left_s;
   assign i_left_sram_rd_end_addr   = r_left_e;
   assign i_down_sram_rd_start_addr = r_down_s;
   assign i_down_sram_rd_end_addr   = r_down_e;

   // State register; reset aborts any transfer in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state plus the per-cycle strobes; idle strobes drive zero addresses/data.
   always_comb begin
      w_state_nxt    = r_state;
      ext_rd_en      = 1'b0;
      ext_rd_addr    = '0;
      ext_wr_en      = 1'b0;
      ext_wr_addr    = '0;
      ext_wr_data    = '0;
      i_top_wr_en    = 1'b0;
      i_top_wr_addr  = '0;
      i_top_wr_data  = '0;
      i_left_wr_en   = 1'b0;
      i_left_wr_addr = '0;
      i_left_wr_data = '0;
      i_down_rd_en   = 1'b0;
      i_down_rd_addr = '0;
      i_ctrl_state   = CTRL_IDLE;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_ld_ok)         w_state_nxt = S_LD_RUN;
               else if (w_st_ok)    w_state_nxt = S_ST_RUN;
               else if (w_gemm_ok)  w_state_nxt = S_GEMM_WAIT;
               else if (w_drain_ok) w_state_nxt = S_DRAIN_WAIT;
            end
         end
         S_LD_RUN: begin
            if (w_rd_phase) begin
               ext_rd_en   = 1'b1;
               ext_rd_addr = r_mem_loc + MW'(r_cnt);
            end
            // read data lands one cycle later, so the write trails by one index
            if (w_wr_phase) begin
               if (r_ld_left) begin
                  i_left_wr_en   = 1'b1;
                  i_left_wr_addr = r_left_wr + LW'(w_wr_idx);
                  i_left_wr_data = LEFTW'(ext_rd_data);
               end else begin
                  i_top_wr_en    = 1'b1;
                  i_top_wr_addr  = r_top_wr + LW'(w_wr_idx);
                  i_top_wr_data  = ext_rd_data;
               end
            end
            if (w_last) w_state_nxt = S_IDLE;
         end
         S_ST_RUN: begin
            if (w_rd_phase) begin
               i_down_rd_en   = 1'b1;
               i_down_rd_addr = r_down_st + LW'(r_cnt);
            end
            if (w_wr_phase) begin
               ext_wr_en   = 1'b1;
               ext_wr_addr = r_mem_loc + MW'(w_wr_idx);
               ext_wr_data = down_rd_data;
            end
            if (w_last) w_state_nxt = S_IDLE;
         end
         S_GEMM_WAIT: begin
            i_ctrl_state = CTRL_GEMM;
            if (ctrl_done) w_state_nxt = S_IDLE;
         end
         S_DRAIN_WAIT: begin
            i_ctrl_state = CTRL_DRAIN;
            if (ctrl_done) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Instruction latch, row counter, bank pointers, controller windows, error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_ld_left    <= 1'b0;
         r_mem_loc    <= '0;
         r_top_wr     <= '0;
         r_left_wr    <= '0;
         r_top_rd     <= '0;
         r_left_rd    <= '0;
         r_down_drain <= '0;
         r_down_st    <= '0;
         r_err        <= 1'b0;
         r_top_s      <= '0;
         r_top_e      <= '0;
         r_left_s     <= '0;
         r_left_e     <= '0;
         r_down_s     <= '0;
         r_down_e     <= '0;
      end else begin
         r_err <= w_accept && !w_legal && !w_nop;
         if (w_accept && w_legal) begin
            r_cnt     <= '0;
            r_mem_loc <= mem_loc;
            r_ld_left <= (buf_id == BUF_LEFT);
         end else if ((r_state == S_LD_RUN) || (r_state == S_ST_RUN)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_accept && w_gemm_ok) begin
            r_top_s  <= r_top_rd;
            r_top_e  <= r_top_rd + LW'(mem_loc) - LW'(1);
            r_left_s <= r_left_rd;
            r_left_e <= r_left_rd + LW'(mem_loc) - LW'(1);
         end
         if (w_accept && w_drain_ok) begin
            r_down_s <= r_down_drain;
            r_down_e <= r_down_drain + ROW_STEP - LW'(1);
         end
         if ((r_state == S_LD_RUN) && w_last) begin
            if (r_ld_left) r_left_wr <= r_left_wr + ROW_STEP;
            else           r_top_wr  <= r_top_wr + ROW_STEP;
         end
         if ((r_state == S_ST_RUN) && w_last) r_down_st <= r_down_st + ROW_STEP;
         if ((r_state == S_GEMM_WAIT) && ctrl_done) begin
            r_top_rd  <= r_top_rd + LW'(r_mem_loc);
            r_left_rd <= r_left_rd + LW'(r_mem_loc);
         end
         if ((r_state == S_DRAIN_WAIT) && ctrl_done) r_down_drain <= r_down_drain + ROW_STEP;
      end
   end

endmodule

// File: tb/tb_gemm_inst_sequencer.sv
// Bench for gemm_inst_sequencer: instruction table plus hand sequences,
// with a queue scoreboard matching every memory/bank strobe.
module tb_gemm_inst_sequencer;
   localparam int OW = 4, BW = 2, MW = 10, NR = 8, NC = 8, DW = 8, AW = 32, CW = 4, LW = 10;
   localparam logic [OW-1:0] OP_LD = 4'h2, OP_ST = 4'h3, OP_GEMM = 4'h4, OP_DR = 4'h5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic inst_valid = 1'b0, inst_ready;
   logic [OW-1:0] opcode = '0;
   logic [BW-1:0] buf_id = '0;
   logic [MW-1:0] mem_loc = '0;
   logic ext_rd_en, ext_wr_en, i_top_wr_en, i_left_wr_en, i_down_rd_en;
   logic [MW-1:0] ext_rd_addr, ext_wr_addr;
   logic [NC*DW-1:0] ext_rd_data = '0, i_top_wr_data;
   logic [NR*DW-1:0] i_left_wr_data;
   logic [NC*AW-1:0] ext_wr_data, down_rd_data = '0;
   logic [LW-1:0] i_top_wr_addr, i_left_wr_addr, i_down_rd_addr;
   logic [CW-1:0] i_ctrl_state;
   logic [LW-1:0] top_s, top_e, left_s, left_e, down_s, down_e;
   logic ctrl_done = 1'b0, busy, err_illegal;

   gemm_inst_sequencer dut (
      .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .opcode(opcode), .buf_id(buf_id), .mem_loc(mem_loc),
      .ext_rd_en(ext_rd_en), .ext_rd_addr(ext_rd_addr), .ext_rd_data(ext_rd_data),
      .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
      .i_top_wr_en(i_top_wr_en), .i_top_wr_addr(i_top_wr_addr), .i_top_wr_data(i_top_wr_data),
      .i_left_wr_en(i_left_wr_en), .i_left_wr_addr(i_left_wr_addr), .i_left_wr_data(i_left_wr_data),
      .i_down_rd_en(i_down_rd_en), .i_down_rd_addr(i_down_rd_addr), .down_rd_data(down_rd_data),
      .i_ctrl_state(i_ctrl_state),
      .i_top_sram_rd_start_addr(top_s), .i_top_sram_rd_end_addr(top_e),
      .i_left_sram_rd_start_addr(left_s), .i_left_sram_rd_end_addr(left_e),
      .i_down_sram_rd_start_addr(down_s), .i_down_sram_rd_end_addr(down_e),
      .ctrl_done(ctrl_done), .busy(busy), .err_illegal(err_illegal)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   task automatic chk(input string nm, input logic [NC*AW-1:0] act, input logic [NC*AW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // memory contents are a fixed function of address
   function automatic logic [NC*DW-1:0] rd_pat(input logic [MW-1:0] a);
      return {4'hF, a, a, a, a, a, a};
   endfunction
   function automatic logic [NC*AW-1:0] down_pat(input logic [LW-1:0] a);
      logic [NC*AW-1:0] r;
      for (int k = 0; k < NC; k++) r[k*AW +: AW] = {16'(16'hC000 + k), 6'h0, a};
      return r;
   endfunction

   // external memory and down bank, 1-cycle read latency
   always @(posedge clk) begin
      ext_rd_data  <= rd_pat(ext_rd_addr);
      down_rd_data <= down_pat(i_down_rd_addr);
   end

   typedef struct packed { logic [LW-1:0] a; logic [NC*DW-1:0] d; } bw_t;
   typedef struct packed { logic [MW-1:0] a; logic [NC*AW-1:0] d; } ew_t;
   logic [MW-1:0] q_rd[$];
   bw_t           q_top[$], q_left[$];
   logic [LW-1:0] q_drd[$];
   ew_t           q_ew[$];

   logic [LW-1:0] m_top_wr = '0, m_left_wr = '0, m_top_rd = '0, m_left_rd = '0;
   logic [LW-1:0] m_down_drain = '0, m_down_st = '0;

   // scoreboard: every strobe must match the oldest expected transfer
   logic [MW-1:0] e_ra; bw_t e_bw; logic [LW-1:0] e_da; ew_t e_ew;
   always @(negedge clk) if (rst_n) begin
      if (ext_rd_en) begin
         if (q_rd.size() == 0) chk("ext_rd_unexpected", ext_rd_addr, '1);
         else begin e_ra = q_rd.pop_front(); chk("ext_rd_addr", ext_rd_addr, e_ra); end
      end
      if (i_top_wr_en) begin
         if (q_top.size() == 0) chk("top_wr_unexpected", i_top_wr_addr, '1);
         else begin
            e_bw = q_top.pop_front();
            chk("top_wr_addr", i_top_wr_addr, e_bw.a);
            chk("top_wr_data", i_top_wr_data, e_bw.d);
         end
      end
      if (i_left_wr_en) begin
         if (q_left.size() == 0) chk("left_wr_unexpected", i_left_wr_addr, '1);
         else begin
            e_bw = q_left.pop_front();
            chk("left_wr_addr", i_left_wr_addr, e_bw.a);
            chk("left_wr_data", i_left_wr_data, e_bw.d);
         end
      end
      if (i_down_rd_en) begin
         if (q_drd.size() == 0) chk("down_rd_unexpected", i_down_rd_addr, '1);
         else begin e_da = q_drd.pop_front(); chk("down_rd_addr", i_down_rd_addr, e_da); end
      end
      if (ext_wr_en) begin
         if (q_ew.size() == 0) chk("ext_wr_unexpected", ext_wr_addr, '1);
         else begin
            e_ew = q_ew.pop_front();
            chk("ext_wr_addr", ext_wr_addr, e_ew.a);
            chk("ext_wr_data", ext_wr_data, e_ew.d);
         end
      end
   end

   typedef struct {
      logic [OW-1:0] op; logic [BW-1:0] bid; logic [MW-1:0] loc;
      int dly;    // wait cycle on which ctrl_done is raised
      logic err;  // expected err_illegal pulse
      int cyc;    // expected cycles with inst_ready low
   } inst_t;
   inst_t tbl[16];

   // push expectations, issue one instruction, run it to completion
   task automatic do_inst(input inst_t v);
      int n;
      logic legal;
      logic [CW-1:0] exp_cs;
      logic [MW-1:0] ra;
      logic [LW-1:0] k, ba;
      bw_t b;
      ew_t w;
      legal  = !v.err && (v.op != '0);
      exp_cs = '0;
      k      = LW'(v.loc);
      @(posedge clk); #1;
      chk("err_quiet", err_illegal, 0);
      chk("ready_idle", inst_ready, 1);
      inst_valid = 1'b1; opcode = v.op; buf_id = v.bid; mem_loc = v.loc;
      if (legal) begin
         if (v.op == OP_LD) begin
            for (int i = 0; i < NR; i++) begin
               ra = v.loc + MW'(i);
               q_rd.push_back(ra);
               b.d = rd_pat(ra);
               if (v.bid == 2'd1) begin b.a = m_left_wr + LW'(i); q_left.push_back(b); end
               else               begin b.a = m_top_wr + LW'(i);  q_top.push_back(b);  end
            end
            if (v.bid == 2'd1) m_left_wr = m_left_wr + LW'(NR);
            else               m_top_wr  = m_top_wr + LW'(NR);
         end else if (v.op == OP_ST) begin
            for (int i = 0; i < NR; i++) begin
               ba = m_down_st + LW'(i);
               q_drd.push_back(ba);
               w.a = v.loc + MW'(i);
               w.d = down_pat(ba);
               q_ew.push_back(w);
            end
            m_down_st = m_down_st + LW'(NR);
         end else if (v.op == OP_GEMM) exp_cs = 4'd1;
         else if (v.op == OP_DR)       exp_cs = 4'd2;
      end
      @(posedge clk); #1;
      inst_valid = 1'b0; opcode = '0; buf_id = '0; mem_loc = '0;
      chk("err_pulse", err_illegal, v.err);
      n = 0;
      while (!inst_ready && n < 40) begin
         n++;
         chk("ctrl_state", i_ctrl_state, exp_cs);
         if (n == 1 && exp_cs == 4'd1) begin
            chk("top_start", top_s, m_top_rd);
            chk("top_end", top_e, LW'(m_top_rd + k - LW'(1)));
            chk("left_start", left_s, m_left_rd);
            chk("left_end", left_e, LW'(m_left_rd + k - LW'(1)));
         end
         if (n == 1 && exp_cs == 4'd2) begin
            chk("down_start", down_s, m_down_drain);
            chk("down_end", down_e, LW'(m_down_drain + LW'(NR - 1)));
         end
         ctrl_done = (exp_cs != '0) && (n == v.dly);
         @(posedge clk); #1;
         ctrl_done = 1'b0;
      end
      chk("busy_cycles", n, v.cyc);
      chk("ctrl_idle_after", i_ctrl_state, 0);
      chk("busy_after", busy, 0);
      if (exp_cs == 4'd1) begin m_top_rd = m_top_rd + k; m_left_rd = m_left_rd + k; end
      if (exp_cs == 4'd2) m_down_drain = m_down_drain + LW'(NR);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{OP_LD,   2'd0, 10'h3FC, 0, 1'b0, 9};
      tbl[1]  = '{OP_LD,   2'd1, 10'h010, 0, 1'b0, 9};
      tbl[2]  = '{OP_LD,   2'd1, 10'h020, 0, 1'b0, 9};
      tbl[3]  = '{OP_GEMM, 2'd0, 10'd4,   5, 1'b0, 5};
      tbl[4]  = '{OP_GEMM, 2'd0, 10'd4,   1, 1'b0, 1};
      tbl[5]  = '{OP_DR,   2'd0, 10'h000, 3, 1'b0, 3};
      tbl[6]  = '{OP_ST,   2'd2, 10'h100, 0, 1'b0, 9};
      tbl[7]  = '{4'hF,    2'd0, 10'h000, 0, 1'b1, 0};
      tbl[8]  = '{OP_LD,   2'd2, 10'h040, 0, 1'b1, 0};
      tbl[9]  = '{OP_GEMM, 2'd0, 10'd0,   0, 1'b1, 0};
      tbl[10] = '{4'h0,    2'd0, 10'h000, 0, 1'b0, 0};
      tbl[11] = '{OP_ST,   2'd0, 10'h080, 0, 1'b1, 0};
      tbl[12] = '{OP_DR,   2'd3, 10'h000, 2, 1'b0, 2};
      tbl[13] = '{OP_LD,   2'd0, 10'h050, 0, 1'b0, 9};
      tbl[14] = '{OP_ST,   2'd2, 10'h3FE, 0, 1'b0, 9};
      tbl[15] = '{OP_GEMM, 2'd1, 10'd3,   2, 1'b0, 2};

      // reset state
      #12;
      chk("rst_ready", inst_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_enables", {ext_rd_en, ext_wr_en, i_top_wr_en, i_left_wr_en, i_down_rd_en}, 0);
      chk("rst_ctrl", i_ctrl_state, 0);
      chk("rst_err", err_illegal, 0);
      chk("rst_addrs", {ext_rd_addr, ext_wr_addr, i_top_wr_addr, top_s, top_e, down_e}, 0);
      @(negedge clk); rst_n = 1'b1;

      for (int t = 0; t < 16; t++) do_inst(tbl[t]);

      // ctrl_done while idle must be ignored
      @(posedge clk); #1; ctrl_done = 1'b1;
      @(posedge clk); #1; ctrl_done = 1'b0;
      chk("done_idle_busy", busy, 0);
      chk("done_idle_ctrl", i_ctrl_state, 0);
      do_inst('{OP_GEMM, 2'd0, 10'd2, 1, 1'b0, 1});
      chk("top_s_held_in_drain", 1'b0, 1'b0 ^ (top_s !== m_top_rd - LW'(2)));
      do_inst('{OP_DR, 2'd0, 10'h000, 1, 1'b0, 1});
      chk("top_s_hold", top_s, LW'(m_top_rd - LW'(2)));

      // reset mid-LD at i=3
      @(posedge clk); #1;
      inst_valid = 1'b1; opcode = OP_LD; buf_id = 2'd0; mem_loc = 10'h200;
      for (int i = 0; i < NR; i++) begin
         q_rd.push_back(10'h200 + MW'(i));
         q_top.push_back('{m_top_wr + LW'(i), rd_pat(10'h200 + MW'(i))});
      end
      @(posedge clk); #1;
      inst_valid = 1'b0; opcode = '0; mem_loc = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("midld_rd_en", ext_rd_en, 1);
      chk("midld_rd_addr", ext_rd_addr, 10'h203);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_enables", {ext_rd_en, ext_wr_en, i_top_wr_en, i_left_wr_en, i_down_rd_en}, 0);
      chk("abort_busy", busy, 0);
      chk("abort_windows", {top_s, left_e, down_e}, 0);
      q_rd.delete(); q_top.delete(); q_left.delete(); q_drd.delete(); q_ew.delete();
      m_top_wr = '0; m_left_wr = '0; m_top_rd = '0; m_left_rd = '0;
      m_down_drain = '0; m_down_st = '0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      chk("post_rst_ready", inst_ready, 1);
      do_inst('{OP_LD, 2'd0, 10'h000, 0, 1'b0, 9});
      do_inst('{OP_GEMM, 2'd0, 10'd2, 2, 1'b0, 2});

      repeat (2) @(posedge clk);
      chk("q_rd_drained", q_rd.size(), 0);
      chk("q_top_drained", q_top.size(), 0);
      chk("q_left_drained", q_left.size(), 0);
      chk("q_drd_drained", q_drd.size(), 0);
      chk("q_ew_drained", q_ew.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
